// File: rtl/wb_pkg.sv
// Shared widths and FSM encoding for the write-back stage and its bitmap assembler.
package wb_pkg;
    localparam int DATA_W   = 16;
    localparam int BM_W     = 1536;
    localparam int BM_WORDS = BM_W / DATA_W;
    localparam int REG_AW   = 4;
    localparam int BM_AW    = 2;
    localparam int CNT_W    = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_stage_bm_assembler.sv
// Collects a stream of DATA_W words into one BM_W bitmap, word 0 in the LSBs.
import wb_pkg::*;

module bm_assembler (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word,
    output logic              done,
    output logic [BM_W-1:0]   bitmap
);
    logic [CNT_W-1:0] count;
    logic [BM_W-1:0]  buffer;

    // bitmap already includes the word arriving this cycle, so the final word
    // can be committed in the same edge that stores it.
    always_comb begin
        bitmap = buffer;
        if (word_valid) begin
            bitmap[DATA_W*int'(count) +: DATA_W] = word;
        end
    end

    assign done = word_valid && (count == CNT_W'(BM_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            buffer <= '0;
        end else if (start) begin
            count <= '0;
        end else if (word_valid) begin
            buffer <= bitmap;
            count  <= done ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registered scalar and bitmap write ports, with LDB word-stream collection.
import wb_pkg::*;

module wb_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_sel_mem,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_bm_write,
    input  logic              in_ldb,
    input  logic [BM_AW-1:0]  in_bm_addr,
    input  logic [BM_W-1:0]   in_bm_data,
    input  logic              mem_word_valid,
    input  logic [DATA_W-1:0] mem_word,
    output logic              stall,
    output logic [REG_AW-1:0] write_reg_addr,
    output logic [DATA_W-1:0] write_reg_data,
    output logic              write_reg_en,
    output logic [BM_AW-1:0]  write_bm_addr,
    output logic [BM_W-1:0]   write_bm_data,
    output logic              write_bm_en
);
    wb_state_e        state, next_state;
    logic [BM_AW-1:0] ldb_addr;
    logic             idle_valid;
    logic             ldb_start;
    logic             asm_word_valid;
    logic             asm_done;
    logic [BM_W-1:0]  asm_bitmap;

    assign idle_valid     = (state == IDLE) && in_valid;
    assign ldb_start      = idle_valid && in_ldb;
    assign asm_word_valid = (state == COLLECT) && mem_word_valid;
    assign stall          = (state != IDLE) || ldb_start;

    bm_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .start      (ldb_start),
        .word_valid (asm_word_valid),
        .word       (mem_word),
        .done       (asm_done),
        .bitmap     (asm_bitmap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ldb_addr <= '0;
        end else begin
            state <= next_state;
            if (ldb_start) begin
                ldb_addr <= in_bm_addr;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ldb_start) next_state = COLLECT;
            COLLECT: if (asm_done)  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Enables pulse for one cycle; addr/data hold their last value otherwise.
    // The LDB commit enable is raised on the edge entering COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg_en   <= 1'b0;
            write_reg_addr <= '0;
            write_reg_data <= '0;
            write_bm_en    <= 1'b0;
            write_bm_addr  <= '0;
            write_bm_data  <= '0;
        end else begin
            write_reg_en <= idle_valid && in_reg_write;
            if (idle_valid && in_reg_write) begin
                write_reg_addr <= in_dest;
                write_reg_data <= in_sel_mem ? in_mem_data : in_alu_result;
            end
            write_bm_en <= 1'b0;
            if (idle_valid && in_bm_write && !in_ldb) begin
                write_bm_en   <= 1'b1;
                write_bm_addr <= in_bm_addr;
                write_bm_data <= in_bm_data;
            end else if (asm_done) begin
                write_bm_en   <= 1'b1;
                write_bm_addr <= ldb_addr;
                write_bm_data <= asm_bitmap;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a negedge monitor checks them.
import wb_pkg::*;

module tb_wb_stage;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_reg_write = 1'b0;
    logic [REG_AW-1:0] in_dest = '0;
    logic              in_sel_mem = 1'b0;
    logic [DATA_W-1:0] in_alu_result = '0;
    logic [DATA_W-1:0] in_mem_data = '0;
    logic              in_bm_write = 1'b0;
    logic              in_ldb = 1'b0;
    logic [BM_AW-1:0]  in_bm_addr = '0;
    logic [BM_W-1:0]   in_bm_data = '0;
    logic              mem_word_valid = 1'b0;
    logic [DATA_W-1:0] mem_word = '0;
    logic              stall;
    logic [REG_AW-1:0] write_reg_addr;
    logic [DATA_W-1:0] write_reg_data;
    logic              write_reg_en;
    logic [BM_AW-1:0]  write_bm_addr;
    logic [BM_W-1:0]   write_bm_data;
    logic              write_bm_en;

    typedef struct { logic [REG_AW-1:0] addr; logic [DATA_W-1:0] data; } reg_exp_t;
    typedef struct { logic [BM_AW-1:0] addr; logic [BM_W-1:0] data; } bm_exp_t;
    reg_exp_t reg_q[$];
    bm_exp_t  bm_q[$];

    int tests = 0;
    int fails = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_dest(in_dest), .in_sel_mem(in_sel_mem), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_bm_write(in_bm_write), .in_ldb(in_ldb),
        .in_bm_addr(in_bm_addr), .in_bm_data(in_bm_data), .mem_word_valid(mem_word_valid),
        .mem_word(mem_word), .stall(stall), .write_reg_addr(write_reg_addr),
        .write_reg_data(write_reg_data), .write_reg_en(write_reg_en),
        .write_bm_addr(write_bm_addr), .write_bm_data(write_bm_data), .write_bm_en(write_bm_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_bm_data(input logic [BM_W-1:0] got, input logic [BM_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            for (int k = 0; k < BM_WORDS; k++) begin
                if (got[DATA_W*k +: DATA_W] !== exp[DATA_W*k +: DATA_W]) begin
                    $display("FAIL bm_data word %0d: got %h expected %h", k,
                             got[DATA_W*k +: DATA_W], exp[DATA_W*k +: DATA_W]);
                    break;
                end
            end
        end
    endtask

    // Monitor: every write pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (write_reg_en) begin
                if (reg_q.size() == 0) begin
                    check("reg_unexpected_en", 32'(write_reg_en), 32'd0);
                end else begin
                    reg_exp_t e;
                    e = reg_q.pop_front();
                    check("reg_addr", 32'(write_reg_addr), 32'(e.addr));
                    check("reg_data", 32'(write_reg_data), 32'(e.data));
                end
            end
            if (write_bm_en) begin
                if (bm_q.size() == 0) begin
                    check("bm_unexpected_en", 32'(write_bm_en), 32'd0);
                end else begin
                    bm_exp_t e;
                    e = bm_q.pop_front();
                    check("bm_addr", 32'(write_bm_addr), 32'(e.addr));
                    check_bm_data(write_bm_data, e.data);
                end
            end
        end
    end

    task automatic issue_reg(input logic [REG_AW-1:0] dest, input logic sel,
                             input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                             input logic [DATA_W-1:0] exp_data);
        reg_exp_t e;
        in_valid = 1'b1; in_reg_write = 1'b1; in_dest = dest;
        in_sel_mem = sel; in_alu_result = alu; in_mem_data = mem;
        e.addr = dest; e.data = exp_data;
        reg_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; in_reg_write = 1'b0;
    endtask

    task automatic accept_ldb(input logic [BM_AW-1:0] addr);
        in_valid = 1'b1; in_ldb = 1'b1; in_bm_addr = addr;
        #1 check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_ldb = 1'b0; in_reg_write = 1'b0; in_bm_write = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input int gap);
        mem_word_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        check("stall_collect", 32'(stall), 32'd1);
        mem_word_valid = 1'b1; mem_word = w;
        @(posedge clk); #1;
        mem_word_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bm_exp_t          be;
        logic [BM_W-1:0]  pat;

        // Reset asserted between edges clears everything without a clock.
        #1 rst = 1'b1;
        #1;
        check("rst_reg_en", 32'(write_reg_en), 32'd0);
        check("rst_bm_en", 32'(write_bm_en), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Scalar writes: ALU then memory source.
        issue_reg(4'd3, 1'b0, 16'h1234, 16'h0000, 16'h1234);
        check("reg_en_pulse", 32'(write_reg_en), 32'd1);
        @(posedge clk); #1;
        check("reg_en_low", 32'(write_reg_en), 32'd0);
        check("reg_addr_hold", 32'(write_reg_addr), 32'd3);
        issue_reg(4'd9, 1'b1, 16'h5555, 16'hBEEF, 16'hBEEF);
        issue_reg(4'd0, 1'b0, 16'h00F0, 16'hFFFF, 16'h00F0);
        @(posedge clk); #1;

        // LDB to register 2 with gaps; scalar requests during COLLECT are ignored.
        be.addr = 2'd2;
        for (int k = 0; k < BM_WORDS; k++) be.data[DATA_W*k +: DATA_W] = 16'(16'h0100 + k);
        bm_q.push_back(be);
        accept_ldb(2'd2);
        in_valid = 1'b1; in_reg_write = 1'b1; in_dest = 4'd7;
        for (int k = 0; k < BM_WORDS; k++) send_word(16'(16'h0100 + k), $urandom_range(0, 2));
        check("bm_en_commit", 32'(write_bm_en), 32'd1);
        check("stall_commit", 32'(stall), 32'd1);
        check("bm_lo_word", 32'(write_bm_data[15:0]), 32'h0100);
        check("bm_hi_word", 32'(write_bm_data[1535:1520]), 32'h015F);
        in_valid = 1'b0; in_reg_write = 1'b0;
        @(posedge clk); #1;
        check("bm_en_after", 32'(write_bm_en), 32'd0);
        check("stall_after", 32'(stall), 32'd0);

        // Reset mid-COLLECT discards the partial bitmap.
        accept_ldb(2'd1);
        for (int k = 0; k < 40; k++) send_word(16'h1111, 0);
        #3 rst = 1'b1;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_bm_addr", 32'(write_bm_addr), 32'd0);
        check("midrst_bm_data0", 32'(write_bm_data[31:0]), 32'd0);
        check("midrst_reg_addr", 32'(write_reg_addr), 32'd0);
        check("midrst_reg_data", 32'(write_reg_data), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Fresh LDB with a simultaneous scalar write; in_bm_write must be ignored.
        be.addr = 2'd3;
        be.data = {BM_WORDS{16'hAAAA}};
        bm_q.push_back(be);
        begin
            reg_exp_t re;
            re.addr = 4'd5; re.data = 16'h0042;
            reg_q.push_back(re);
        end
        in_reg_write = 1'b1; in_dest = 4'd5; in_sel_mem = 1'b0; in_alu_result = 16'h0042;
        in_bm_write = 1'b1; in_bm_data = {BM_W{1'b1}};
        accept_ldb(2'd3);
        for (int k = 0; k < BM_WORDS - 1; k++) send_word(16'hAAAA, 0);
        check("stall_before_last", 32'(stall), 32'd1);
        send_word(16'hAAAA, 0);
        check("bm_en_fresh", 32'(write_bm_en), 32'd1);
        @(posedge clk); #1;

        // Direct bitmap write with stray stream pulses in IDLE.
        for (int k = 0; k < BM_WORDS; k++) pat[DATA_W*k +: DATA_W] = 16'(16'hC3C3 ^ (k * 16'h0101));
        mem_word = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            mem_word_valid = 1'b1;
            #1 check("stray_stall_pre", 32'(stall), 32'd0);
            @(posedge clk); #1;
        end
        be.addr = 2'd1; be.data = pat;
        bm_q.push_back(be);
        in_valid = 1'b1; in_bm_write = 1'b1; in_bm_addr = 2'd1; in_bm_data = pat;
        #1 check("direct_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_bm_write = 1'b0;
        check("direct_bm_en", 32'(write_bm_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stray_stall_post", 32'(stall), 32'd0);
            check("stray_bm_en", 32'(write_bm_en), 32'd0);
        end
        mem_word_valid = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("reg_q_drained", 32'(reg_q.size()), 32'd0);
        check("bm_q_drained", 32'(bm_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
